mux_scan_nx1: RTL
=================

// Module: mux_scan_nx1
// PURPOSE
//   Parametrised N-to-1 registered channel multiplexer with a valid/ready output.
//   Manual mode: selects the channel given by sel. Auto mode: a round-robin scan
//   pointer selects the channel. Captures one beat per free output slot and
//   acknowledges the source channel.
//   Sits between per-channel sources and a single shared downstream consumer.
// PARAMETERS
//   NUM_CH  16  number of input channels, >=2; need not be a power of 2
//   DATA_W  1   width of each channel's data
//   SEL_W   $clog2(NUM_CH)  localparam; width of sel, out_ch and the scan pointer
// PORTS
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous, active-high reset
//   in_data    in   NUM_CH*DATA_W  channel k occupies in_data[k*DATA_W +: DATA_W]
//   in_valid   in   NUM_CH         per-channel data-valid
//   in_ack     out  NUM_CH         combinational one-hot; channel consumed this cycle
//   mode       in   1              0 = manual (sel), 1 = auto scan
//   sel        in   SEL_W          channel select, used in manual mode only
//   out_data   out  DATA_W         registered selected data
//   out_ch     out  SEL_W          registered source channel of out_data
//   out_valid  out  1              output beat valid
//   out_ready  in   1              downstream accepts the beat
//   ch_mask    in   NUM_CH         only with MUX_SCAN_MASK_EN; 1 = channel enabled
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ch=0, scan_ptr=0.
//     in_ack=0 during every cycle in which rst=1.
//   - Slot free (load): ~out_valid | out_ready.
//   - cur = mode ? scan_ptr : sel. Decode uses the current cycle's mode and sel.
//   - load & cur<NUM_CH & in_valid[cur]:
//       next edge: out_data<=slice(cur), out_ch<=cur, out_valid<=1.
//       in_ack[cur]=1 in the same cycle.
//   - load otherwise: out_valid<=0; out_data/out_ch hold; in_ack=0.
//   - Not load (out_valid & ~out_ready): all outputs hold; in_ack=0; scan_ptr holds.
//   - Latency: 1 cycle from capture to out_valid.
//     Full throughput of 1 beat/cycle while out_ready=1.
//   - Auto mode, load cycle: scan_ptr advances whether or not cur was captured.
//     This prevents lock-up on an idle channel. Wraps NUM_CH-1 -> 0.
//   - Manual mode: scan_ptr holds. Switching mode never resets scan_ptr.
//   - sel >= NUM_CH (non-power-of-2 NUM_CH): no capture, in_ack=0.
//   - A source sees in_ack only when its beat is taken; it must hold its data until then.
//   - rst asserted mid-stream: the pending beat is dropped; next cycle equals reset state.
// CONFIGURATION
//   MUX_SCAN_MASK_EN defined:
//     - Port ch_mask exists. Masked channels are never captured in either mode
//       (in_ack=0, out_valid<=0 on load).
//     - Auto-mode advance: scan_ptr jumps to the first enabled channel after scan_ptr,
//       wrapping round.
//     - Only scan_ptr itself enabled: scan_ptr stays.
//     - ch_mask all zero: scan_ptr holds and there is no capture.
//   MUX_SCAN_MASK_EN undefined:
//     - Port ch_mask absent; all channels enabled; advance is always +1.
// TESTING
//   1. NUM_CH=16, DATA_W=1, manual; in_data=16'hA5C3 all valid, sel=0..15, out_ready=1
//      -> out_data=in_data[sel] one cycle later; out_ch=sel; in_ack one-hot.
//   2. Auto mode, all valid, out_ready=1 for 20 cycles
//      -> out_ch sequence 0..15,0..3; one in_ack per cycle.
//   3. Auto mode, out_ready=0 for 3 cycles holding out_ch=5
//      -> out_data/out_ch/out_valid stable, in_ack=0, scan_ptr stays 6;
//         release gives out_ch=6 next.
//   4. NUM_CH=6, DATA_W=8, manual, sel=7 -> out_valid=0, in_ack=0.
//      Auto mode, only ch 2 valid -> one capture per 6 cycles.
//   5. rst pulsed while out_valid=1, scan_ptr=9
//      -> next cycle out_valid=0, out_ch=0, scan_ptr=0, in_ack=0.
//   6. MUX_SCAN_MASK_EN, ch_mask=16'h0101, auto mode, all valid
//      -> out_ch alternates 0,8; ch_mask=0 -> out_valid=0, no in_ack.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// N-to-1 registered channel mux with manual select or round-robin scan.
// Optional channel masking: define MUX_SCAN_MASK_EN to add the ch_mask port.
module mux_scan_nx1 #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ack,
    input  logic                      mode,
    input  logic [$clog2(NUM_CH)-1:0] sel,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_SCAN_MASK_EN
  , input  logic [NUM_CH-1:0]         ch_mask
`endif
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [SEL_W-1:0]  ptr_q, ptr_d, ptr_nxt;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic [NUM_CH-1:0] en_mask;
    logic [SEL_W-1:0]  cur;
    logic [DATA_W-1:0] cur_data;
    logic              cur_ok;
    logic              load;
    logic              take;

`ifdef MUX_SCAN_MASK_EN
    assign en_mask = ch_mask;
`else
    assign en_mask = '1;
`endif

    // Out-of-range selects match no channel, so they never capture.
    always_comb begin
        cur      = mode ? ptr_q : sel;
        load     = ~valid_q | out_ready;
        cur_ok   = 1'b0;
        cur_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur == SEL_W'(k)) begin
                cur_ok   = in_valid[k] & en_mask[k];
                cur_data = in_data[k*DATA_W +: DATA_W];
            end
        end
        take   = ~rst & load & cur_ok;
        in_ack = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ack[k] = take & (cur == SEL_W'(k));
        end
    end

`ifdef MUX_SCAN_MASK_EN
    int               idx;
    logic [SEL_W-1:0] idx_s;

    // Walk offsets downward so the nearest enabled channel wins.
    always_comb begin
        ptr_nxt = ptr_q;
        idx     = 0;
        idx_s   = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_s = SEL_W'(idx);
            if (en_mask[idx_s]) begin
                ptr_nxt = idx_s;
            end
        end
    end
`else
    always_comb begin
        ptr_nxt = (int'(ptr_q) == NUM_CH - 1) ? '0 : ptr_q + SEL_W'(1);
    end
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = take;
            if (take) begin
                data_d = cur_data;
                ch_d   = cur;
            end
            // Advance even on a miss so an idle channel cannot stall the scan.
            if (mode) begin
                ptr_d = ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule
